alu_ctrl_sequencer: RTL and testbench
=====================================

// Module: alu_ctrl_sequencer
// PURPOSE
//  Registered, parametrised ALU-control generator for the next MIPS core revision.
//  Decodes ALUOp plus the full 6-bit funct field into an ALU control word.
//  Sequences the multi-cycle MULT/DIV family with a counter and a valid/ready handshake.
//  Sits between the main control unit and the ALU / HI-LO unit.
// PARAMETERS
//  CTR_W      4  ALU control width; legacy codes zero-extended in the MSB (>=4 required)
//  MUL_CYCLES 4  cycles MULT/MULTU occupies the ALU (>=2)
//  DIV_CYCLES 8  cycles DIV/DIVU occupies the ALU (>=2)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      decode request present
//  in_ready   out  1      block accepts a request this cycle
//  alu_op     in   2      00 add (lw/sw), 01 sub (beq), 10 R-type (use func_code), 11 reserved
//  func_code  in   6      instruction funct field
//  flush      in   1      abort in-flight op, return to IDLE
//  alu_ctr    out  CTR_W  registered ALU control word
//  out_valid  out  1      alu_ctr valid, one-cycle pulse per op
//  busy       out  1      multi-cycle op in progress
//  hilo_we    out  1      HI/LO write strobe, coincident with final out_valid of MULT/DIV
//  illegal    out  1      unknown funct/alu_op (ILLEGAL_TRAP_EN only; else tied 0)
// BEHAVIOUR
//  Reset (async): state=IDLE; alu_ctr=0, out_valid=0, busy=0, hilo_we=0, illegal=0, counter=0.
//  Decode (alu_op=10): ADD/ADDU 10000x->0101; SUB/SUBU 10001x->0110; AND 100100->0000;
//   OR 100101->0001; SLT 101010->0100; MOVZ/MOVN 00101x->0111; MFHI 010000->1010;
//   MFLO 010010->1011; MULT/MULTU 01100x->1000; DIV/DIVU 01101x->1001.
//   alu_op 00->0101, 01->0110. Full 6-bit compare; a bare func[3] match is not a move.
//  FSM IDLE/BUSY. in_ready = (state==IDLE) & ~flush.
//  IDLE, accept (in_valid&in_ready), single-cycle code: next cycle alu_ctr=code, out_valid=1.
//   Latency is 1 cycle. Back-to-back accepts every cycle are allowed.
//  IDLE, accept MULT/DIV: -> BUSY; counter loads MUL_CYCLES-1 or DIV_CYCLES-1.
//   busy=1 and alu_ctr is held while in BUSY.
//  BUSY: counter decrements each cycle; in_ready=0; in_valid is ignored.
//   At counter==1, the next cycle has out_valid=1, hilo_we=1, busy=0, state=IDLE.
//   Total occupancy is exactly N cycles from acceptance to out_valid.
//  flush (any state): next cycle is IDLE, busy=0, out_valid=0, hilo_we=0, counter=0.
//   alu_ctr keeps its last value. flush beats a same-cycle in_valid; that request is dropped.
//  No accept in a cycle: out_valid=0 and hilo_we=0 in the following cycle.
//  Reset asserted mid-BUSY: outputs clear immediately; no hilo_we is issued.
//  Counter width is $clog2(max(MUL_CYCLES,DIV_CYCLES)); it never wraps below 0.
// CONFIGURATION
//  ALU_CTRL_ILLEGAL_TRAP_EN defined:
//   Unknown funct or alu_op=11 yields illegal=1 and out_valid=1 in the next cycle.
//   alu_ctr is unchanged and no BUSY entry occurs.
//  Undefined: unknown codes decode as add (0101); illegal is tied 0.
// STRUCTURE
//  Package mips_alu_pkg holds:
//   ALU control code localparams (ALU_AND..ALU_DIV), funct constants, ALUOp constants.
//   State encoding ST_IDLE/ST_BUSY.
//  Sub-module alu_func_decode: purely combinational funct/alu_op -> code, is_multi, is_illegal.
//  The top level holds only the FSM, counter and output registers.
// TESTING
//  1 Reset: rst_n=0 mid-cycle -> all outputs 0 asynchronously; in_ready=1 after release.
//  2 Single-cycle: alu_op=10, func=100100 then 101010 on consecutive cycles
//    -> alu_ctr 0000 then 0100, out_valid high 2 cycles, in_ready stays 1.
//  3 MULT: func=011000 accepted at T -> busy T+1..T+3; in_ready=0 for those cycles;
//    out_valid=hilo_we=1 at T+4, alu_ctr=1000.
//  4 DIV with flush at T+3: busy=0 at T+4, no hilo_we ever, next request accepted at T+4.
//  5 alu_op=00/01 -> 0101/0110 regardless of func; func=001010 -> 0111; func=001000 is not a move.
//  6 func=111111: trap build -> illegal=1, out_valid=1;
//    non-trap build -> alu_ctr=0101, illegal=0.

Source files
------------

// File: rtl/alu_ctrl_sequencer_pkg.sv
// rtl/alu_ctrl_sequencer_pkg.sv - ALU control codes, funct/ALUOp constants and FSM encoding
// Package mips_alu_pkg: shared by the decoder, the interface users and the sequencer top.
package mips_alu_pkg;

    // ALU control codes (legacy 4-bit values, zero-extended at the top level)
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_ADD  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_MOV  = 4'b0111;
    localparam logic [3:0] ALU_MULT = 4'b1000;
    localparam logic [3:0] ALU_DIV  = 4'b1001;
    localparam logic [3:0] ALU_MFHI = 4'b1010;
    localparam logic [3:0] ALU_MFLO = 4'b1011;

    // R-type funct field values
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_MOVZ  = 6'b001010;
    localparam logic [5:0] FN_MOVN  = 6'b001011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    // ALUOp from the main control unit
    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_RTYPE = 2'b10;
    localparam logic [1:0] AOP_RSVD  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic logic is_multi_code(input logic [3:0] code);
        return (code == ALU_MULT) || (code == ALU_DIV);
    endfunction

endpackage

// File: rtl/alu_ctrl_sequencer_if.sv
// rtl/alu_ctrl_sequencer_if.sv - request/response bundle between control unit and ALU-control sequencer
// master (control-unit side): drives in_valid, alu_op, func_code, flush; observes the rest.
// slave  (sequencer side)   : drives in_ready, alu_ctr, out_valid, busy, hilo_we, illegal.
interface alu_ctrl_sequencer_if #(
    parameter int CTR_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [5:0]       func_code;
    logic             flush;
    logic [CTR_W-1:0] alu_ctr;
    logic             out_valid;
    logic             busy;
    logic             hilo_we;
    logic             illegal;

    modport master (
        output in_valid, alu_op, func_code, flush,
        input  in_ready, alu_ctr, out_valid, busy, hilo_we, illegal
    );

    modport slave (
        input  in_valid, alu_op, func_code, flush,
        output in_ready, alu_ctr, out_valid, busy, hilo_we, illegal
    );
endinterface

// File: rtl/alu_ctrl_sequencer_decode.sv
// rtl/alu_ctrl_sequencer_decode.sv - combinational ALUOp/funct to ALU control code decoder
// Module alu_func_decode.
//  i_alu_op     in  2  ALUOp from main control
//  i_func       in  6  instruction funct field
//  o_code       out 4  ALU control code
//  o_is_multi   out 1  code selects MULT/MULTU or DIV/DIVU
//  o_is_illegal out 1  unknown funct or reserved ALUOp (only with ALU_CTRL_ILLEGAL_TRAP_EN)
// Macro ALU_CTRL_ILLEGAL_TRAP_EN: when undefined, unknown codes decode as add and o_is_illegal is 0.
module alu_func_decode (
    input  logic [1:0] i_alu_op,
    input  logic [5:0] i_func,
    output logic [3:0] o_code,
    output logic       o_is_multi,
    output logic       o_is_illegal
);
    import mips_alu_pkg::*;

    // Full 6-bit compares throughout: 001000 (jr) must not alias the move codes.
    always_comb begin
        o_code       = ALU_ADD;
        o_is_illegal = 1'b0;
        case (i_alu_op)
            AOP_ADD:   o_code = ALU_ADD;
            AOP_SUB:   o_code = ALU_SUB;
            AOP_RTYPE: begin
                case (i_func)
                    FN_ADD,  FN_ADDU:  o_code = ALU_ADD;
                    FN_SUB,  FN_SUBU:  o_code = ALU_SUB;
                    FN_AND:            o_code = ALU_AND;
                    FN_OR:             o_code = ALU_OR;
                    FN_SLT:            o_code = ALU_SLT;
                    FN_MOVZ, FN_MOVN:  o_code = ALU_MOV;
                    FN_MFHI:           o_code = ALU_MFHI;
                    FN_MFLO:           o_code = ALU_MFLO;
                    FN_MULT, FN_MULTU: o_code = ALU_MULT;
                    FN_DIV,  FN_DIVU:  o_code = ALU_DIV;
                    default: begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                        o_is_illegal = 1'b1;
`endif
                    end
                endcase
            end
            AOP_RSVD: begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                o_is_illegal = 1'b1;
`endif
            end
            default: o_code = ALU_ADD;
        endcase
    end

    assign o_is_multi = is_multi_code(o_code);

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// rtl/alu_ctrl_sequencer.sv - registered ALU-control generator with MULT/DIV occupancy sequencing
// Module alu_ctrl_sequencer.
//  clk    in  1  rising-edge clock
//  rst_n  in  1  asynchronous active-low reset
//  bus    slave modport of alu_ctrl_sequencer_if (in_valid/in_ready request, alu_ctr/out_valid
//         response, busy, hilo_we, illegal, flush)
// Parameters: CTR_W (>=4), MUL_CYCLES (>=2), DIV_CYCLES (>=2).
// Macro ALU_CTRL_ILLEGAL_TRAP_EN enables illegal-op reporting through the decoder.
module alu_ctrl_sequencer #(
    parameter int CTR_W      = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_ctrl_sequencer_if.slave  bus
);
    import mips_alu_pkg::*;

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MUL  = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CTR_W-1:0]   r_alu_ctr;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_hilo_we;
    logic               r_illegal;

    logic [3:0]         w_code;
    logic [CTR_W-1:0]   w_code_ext;
    logic               w_is_multi;
    logic               w_is_illegal;
    logic               w_in_ready;
    logic               w_accept;

    alu_func_decode u_decode (
        .i_alu_op     (bus.alu_op),
        .i_func       (bus.func_code),
        .o_code       (w_code),
        .o_is_multi   (w_is_multi),
        .o_is_illegal (w_is_illegal)
    );

    always_comb begin
        w_code_ext      = '0;
        w_code_ext[3:0] = w_code;
    end

    assign w_in_ready = (r_state == ST_IDLE) && !bus.flush;
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_alu_ctr   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_hilo_we   <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses unless re-asserted below.
            r_out_valid <= 1'b0;
            r_hilo_we   <= 1'b0;
            r_illegal   <= 1'b0;
            if (bus.flush) begin
                // alu_ctr deliberately keeps its last value across a flush.
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            if (w_is_illegal) begin
                                r_illegal   <= 1'b1;
                                r_out_valid <= 1'b1;
                            end else if (w_is_multi) begin
                                r_alu_ctr <= w_code_ext;
                                r_state   <= ST_BUSY;
                                r_busy    <= 1'b1;
                                r_cnt     <= (w_code == ALU_DIV) ? CNT_DIV : CNT_MUL;
                            end else begin
                                r_alu_ctr   <= w_code_ext;
                                r_out_valid <= 1'b1;
                            end
                        end
                    end
                    ST_BUSY: begin
                        // Loaded with N-1 at accept, so completion lands N cycles later.
                        if (r_cnt <= CNT_ONE) begin
                            r_state     <= ST_IDLE;
                            r_busy      <= 1'b0;
                            r_cnt       <= '0;
                            r_out_valid <= 1'b1;
                            r_hilo_we   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.alu_ctr   = r_alu_ctr;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.hilo_we   = r_hilo_we;
    assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// tb/tb_alu_ctrl_sequencer.sv - self-checking bench for alu_ctrl_sequencer
module tb_alu_ctrl_sequencer;

    localparam int MUL_N = 4;
    localparam int DIV_N = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    // Reference model: cycles left before a MULT/DIV result, plus last issued code.
    int         m_rem;
    logic [3:0] m_ctr;
    logic       m_ov;
    logic       m_hilo;
    logic       m_ill;

    alu_ctrl_sequencer_if #(.CTR_W(4)) bus ();

    alu_ctrl_sequencer #(
        .CTR_W      (4),
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Spec decode table; -1 means the combination has no defined code.
    function automatic int ref_lookup(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'd0) return 5;
        if (op == 2'd1) return 6;
        if (op == 2'd3) return -1;
        case (int'(fn))
            32, 33: return 5;
            34, 35: return 6;
            36:     return 0;
            37:     return 1;
            42:     return 4;
            10, 11: return 7;
            16:     return 10;
            18:     return 11;
            24, 25: return 8;
            26, 27: return 9;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_rem  = 0;
        m_ctr  = 4'd0;
        m_ov   = 1'b0;
        m_hilo = 1'b0;
        m_ill  = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic fl, input logic [1:0] op, input logic [5:0] fn);
        int c;
        m_ov   = 1'b0;
        m_hilo = 1'b0;
        m_ill  = 1'b0;
        if (fl) begin
            m_rem = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_ov   = 1'b1;
                m_hilo = 1'b1;
            end
        end else if (v) begin
            c = ref_lookup(op, fn);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            if (c < 0) begin
                m_ill = 1'b1;
                m_ov  = 1'b1;
                return;
            end
`else
            if (c < 0) c = 5;
`endif
            m_ctr = 4'(c);
            if (c == 8)      m_rem = MUL_N - 1;
            else if (c == 9) m_rem = DIV_N - 1;
            else             m_ov  = 1'b1;
        end
    endtask

    task automatic check_outputs();
        check("out_valid", bus.out_valid, m_ov);
        check("alu_ctr",   bus.alu_ctr,   m_ctr);
        check("busy",      bus.busy,      m_rem > 0);
        check("hilo_we",   bus.hilo_we,   m_hilo);
        check("illegal",   bus.illegal,   m_ill);
    endtask

    // One clock: drive at negedge, check in_ready, model the edge, check registered outputs.
    task automatic cyc(input logic v, input logic fl, input logic [1:0] op, input logic [5:0] fn);
        bus.in_valid  = v;
        bus.flush     = fl;
        bus.alu_op    = op;
        bus.func_code = fn;
        #1;
        check("in_ready", bus.in_ready, (m_rem == 0) && !fl);
        @(posedge clk);
        model_edge(v, fl, op, fn);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd2, 6'd0);
    endtask

    initial begin
        logic [5:0] known [15];
        known = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd42, 6'd10,
                  6'd11, 6'd16, 6'd18, 6'd24, 6'd25, 6'd26, 6'd27};
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.alu_op    = 2'd0;
        bus.func_code = 6'd0;

        // 1 Reset state
        #3;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_alu_ctr",   bus.alu_ctr,   4'd0);
        check("rst_busy",      bus.busy,      1'b0);
        check("rst_hilo_we",   bus.hilo_we,   1'b0);
        check("rst_illegal",   bus.illegal,   1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 1'b1);

        // 2 Back-to-back single-cycle ops
        cyc(1'b1, 1'b0, 2'd2, 6'b100100);
        check("t2_and_code", bus.alu_ctr, 4'b0000);
        check("t2_and_ov",   bus.out_valid, 1'b1);
        cyc(1'b1, 1'b0, 2'd2, 6'b101010);
        check("t2_slt_code", bus.alu_ctr, 4'b0100);
        check("t2_slt_ov",   bus.out_valid, 1'b1);
        idle(1);

        // 3 MULT occupies exactly MUL_N cycles
        cyc(1'b1, 1'b0, 2'd2, 6'b011000);
        for (int i = 1; i < MUL_N; i++) begin
            check("t3_busy", bus.busy, 1'b1);
            check("t3_ov_low", bus.out_valid, 1'b0);
            cyc(1'b1, 1'b0, 2'd2, 6'b100100);
        end
        check("t3_ov",   bus.out_valid, 1'b1);
        check("t3_hilo", bus.hilo_we,   1'b1);
        check("t3_code", bus.alu_ctr,   4'b1000);
        check("t3_busy_done", bus.busy, 1'b0);
        idle(1);

        // 4 DIV flushed at T+3, new request accepted at T+4
        cyc(1'b1, 1'b0, 2'd2, 6'b011010);
        idle(2);
        cyc(1'b0, 1'b1, 2'd2, 6'd0);
        check("t4_busy_flushed", bus.busy, 1'b0);
        check("t4_ctr_kept", bus.alu_ctr, 4'b1001);
        cyc(1'b1, 1'b0, 2'd2, 6'b100101);
        check("t4_next_code", bus.alu_ctr, 4'b0001);
        idle(DIV_N + 2);
        // flush beats a same-cycle request
        cyc(1'b1, 1'b1, 2'd2, 6'b100000);
        check("t4_flush_drop", bus.out_valid, 1'b0);

        // 5 ALUOp add/sub ignore funct; move codes need the full funct
        cyc(1'b1, 1'b0, 2'd0, 6'($urandom));
        check("t5_aop00", bus.alu_ctr, 4'b0101);
        cyc(1'b1, 1'b0, 2'd1, 6'($urandom));
        check("t5_aop01", bus.alu_ctr, 4'b0110);
        cyc(1'b1, 1'b0, 2'd2, 6'b001010);
        check("t5_movz", bus.alu_ctr, 4'b0111);
        cyc(1'b1, 1'b0, 2'd2, 6'b001000);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        check("t5_jr_illegal", bus.illegal, 1'b1);
        check("t5_jr_ctr_kept", bus.alu_ctr, 4'b0111);
`else
        check("t5_jr_add", bus.alu_ctr, 4'b0101);
`endif

        // 6 Unknown funct 111111
        cyc(1'b1, 1'b0, 2'd2, 6'b111111);
        check("t6_ov", bus.out_valid, 1'b1);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        check("t6_illegal", bus.illegal, 1'b1);
        check("t6_busy", bus.busy, 1'b0);
`else
        check("t6_code", bus.alu_ctr, 4'b0101);
        check("t6_illegal", bus.illegal, 1'b0);
`endif

        // Reset asserted mid-DIV clears outputs at once and suppresses hilo_we
        cyc(1'b1, 1'b0, 2'd2, 6'b011011);
        idle(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy",    bus.busy,      1'b0);
        check("midrst_alu_ctr", bus.alu_ctr,   4'd0);
        check("midrst_ov",      bus.out_valid, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(DIV_N + 2);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic       v;
            logic       fl;
            logic [1:0] op;
            logic [5:0] fn;
            v  = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 19) == 0);
            op = ($urandom_range(0, 9) < 8) ? 2'd2 : 2'($urandom);
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : known[$urandom_range(0, 14)];
            cyc(v, fl, op, fn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
